vga_timing_640_480: RTL and testbench

- Upstream timing stage for the 640x480@60 Hz pixel generator.
- Divides the system clock into a pixel-rate enable.
- Runs the horizontal and vertical counters.
- Produces the sync, active-area and pixel-index signals that the colour generator consumes, plus the physical sync pins.

---
 rtl/vga_timing_640_480_pkg.sv | 29 ++
 rtl/vga_timing_640_480_counter.sv | 32 +++
 rtl/vga_timing_640_480.sv | 103 ++++++++++
 tb/tb_vga_timing_640_480.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_640_480_pkg.sv
// rtl/vga_timing_640_480_pkg.sv - shared 640x480@60 timing constants
// Purpose : one place for the H/V active, porch, sync and derived totals,
//           used by the timing stage and by the colour generator's
//           active-area bounds.
// Ports   : none (package).
package vga_timing_640_480_pkg;

  localparam int VGA_CLK_DIV  = 4;    // 100 MHz system clock -> 25 MHz pixels

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 800
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 525

  // Sync windows are [start, end): first pulse position, first position after it.
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;                  // 656
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;            // 752
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;                  // 490
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;            // 492

endpackage

// File: rtl/vga_timing_640_480_counter.sv
// rtl/vga_timing_640_480_counter.sv - enabled wrap-at-MAX counter (counterN_en)
// Purpose : counts 0..MAX on each enabled clk, then returns to 0.
// Ports   : clk  - system clock
//           clr  - asynchronous active-high clear
//           en   - count enable
//           cnt  - current count
//           wrap - en && count at (or beyond) MAX; the count returns to 0 on this clk
module counterN_en #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  // ">=" rather than "==" so an out-of-range count (upset) recovers on the next enable.
  logic at_last;
  assign at_last = (cnt >= MAX);
  assign wrap    = en && at_last;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_timing_640_480.sv
// rtl/vga_timing_640_480.sv - 640x480@60 pixel enable, counters and sync decode
// Purpose : divides clk into a pixel enable, runs the horizontal/vertical
//           counters and decodes sync, active-area and pixel index.
// Ports   : clk         - system clock
//           i_sclr      - asynchronous active-high reset
//           o_px_clk    - one-clk pixel enable every CLK_DIV clks
//           o_hsync_en  - horizontal sync window
//           o_vsync_en  - vertical sync window
//           o_haddr_en  - horizontal active region
//           o_vaddr_en  - vertical active region
//           o_hidx      - active column, 0 outside active region
//           o_vidx      - active line, 0 outside active region
//           o_vga_hsync - HSYNC pin, active-low
//           o_vga_vsync - VSYNC pin, active-low
//           o_frame_end - pulse on the last pixel enable of a frame
module vga_timing_640_480
  import vga_timing_640_480_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       i_sclr,
  output logic       o_px_clk,
  output logic       o_hsync_en,
  output logic       o_vsync_en,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_vga_hsync,
  output logic       o_vga_vsync,
  output logic       o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             px_en;
  logic             h_wrap;
  logic             v_wrap;

  // Free-running divider; its wrap flag is the pixel enable.
  counterN_en #(.WIDTH(DIV_W), .MAX(DIV_LAST)) u_div (
    .clk  (clk),
    .clr  (i_sclr),
    .en   (1'b1),
    .cnt  (div_cnt),
    .wrap (px_en)
  );

  counterN_en #(.WIDTH(10), .MAX(H_LAST)) u_h_cnt (
    .clk  (clk),
    .clr  (i_sclr),
    .en   (px_en),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  // Line counter steps on the pixel enable that ends a line; its wrap is
  // therefore the last pixel enable of the frame.
  counterN_en #(.WIDTH(10), .MAX(V_LAST)) u_v_cnt (
    .clk  (clk),
    .clr  (i_sclr),
    .en   (h_wrap),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  assign o_px_clk    = px_en;
  assign o_frame_end = v_wrap;

  assign o_haddr_en  = (h_cnt < H_ACT);
  assign o_vaddr_en  = (v_cnt < V_ACT);
  assign o_hsync_en  = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign o_vsync_en  = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign o_hidx      = o_haddr_en ? h_cnt : 10'd0;
  assign o_vidx      = o_vaddr_en ? v_cnt[8:0] : 9'd0;
  assign o_vga_hsync = ~o_hsync_en;
  assign o_vga_vsync = ~o_vsync_en;

endmodule

// File: tb/tb_vga_timing_640_480.sv
// tb/tb_vga_timing_640_480.sv - directed self-checking bench for vga_timing_640_480
module tb_vga_timing_640_480;

  logic clk = 1'b0;
  logic rst;

  // Full-size instance.
  logic       px, hs, vs, ha, va, vgah, vgav, fe;
  logic [9:0] hidx;
  logic [8:0] vidx;

  // Shrunk instance so whole frames fit in a short run.
  logic       s_px, s_hs, s_vs, s_ha, s_va, s_vgah, s_vgav, s_fe;
  logic [9:0] s_hidx;
  logic [8:0] s_vidx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_640_480 dut (
    .clk(clk), .i_sclr(rst), .o_px_clk(px), .o_hsync_en(hs), .o_vsync_en(vs),
    .o_haddr_en(ha), .o_vaddr_en(va), .o_hidx(hidx), .o_vidx(vidx),
    .o_vga_hsync(vgah), .o_vga_vsync(vgav), .o_frame_end(fe)
  );

  vga_timing_640_480 #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .i_sclr(rst), .o_px_clk(s_px), .o_hsync_en(s_hs), .o_vsync_en(s_vs),
    .o_haddr_en(s_ha), .o_vaddr_en(s_va), .o_hidx(s_hidx), .o_vidx(s_vidx),
    .o_vga_hsync(s_vgah), .o_vga_vsync(s_vgav), .o_frame_end(s_fe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs after k clk edges since reset release, straight from the timing rules.
  function automatic logic [26:0] expect_vec(input int k, input int d,
                                             input int ha_n, input int hf, input int hsw, input int hb,
                                             input int va_n, input int vf, input int vsw, input int vb);
    int ht, vt, p, h, v;
    logic e_px, e_ha, e_va, e_hs, e_vs, e_fe;
    logic [9:0] e_hi;
    logic [8:0] e_vi;
    ht   = ha_n + hf + hsw + hb;
    vt   = va_n + vf + vsw + vb;
    p    = k / d;
    h    = p % ht;
    v    = (p / ht) % vt;
    e_px = ((k % d) == d - 1);
    e_ha = (h < ha_n);
    e_va = (v < va_n);
    e_hs = (h >= ha_n + hf) && (h < ha_n + hf + hsw);
    e_vs = (v >= va_n + vf) && (v < va_n + vf + vsw);
    e_hi = e_ha ? 10'(h) : 10'd0;
    e_vi = e_va ? 9'(v) : 9'd0;
    e_fe = e_px && (h == ht - 1) && (v == vt - 1);
    return {e_px, e_fe, e_ha, e_va, e_hs, e_vs, ~e_hs, ~e_vs, e_hi, e_vi};
  endfunction

  function automatic logic [26:0] exp_big(input int k);
    return expect_vec(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [26:0] exp_small(input int k);
    return expect_vec(k, 2, 8, 2, 3, 2, 4, 1, 2, 1);
  endfunction

  function automatic logic [26:0] got_big();
    return {px, fe, ha, va, hs, vs, vgah, vgav, hidx, vidx};
  endfunction

  function automatic logic [26:0] got_small();
    return {s_px, s_fe, s_ha, s_va, s_hs, s_vs, s_vgah, s_vgav, s_hidx, s_vidx};
  endfunction

  initial begin
    int ha_cnt, hs_cnt, hs_first_k, hs_last_k, hs_rises;
    int s_va_cnt, s_vs_cnt, s_fe_cnt, s_fe_last;
    logic prev_hs;

    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset_big",   32'(got_big()),   32'(exp_big(0)));
    check("reset_small", 32'(got_small()), 32'(exp_small(0)));
    check("reset_hsync_pin", 32'(vgah), 32'd1);
    check("reset_vsync_pin", 32'(vgav), 32'd1);
    check("reset_hidx", 32'(hidx), 32'd0);

    rst = 1'b0;
    ha_cnt = 0; hs_cnt = 0; hs_first_k = -1; hs_last_k = -1; hs_rises = 0;
    s_va_cnt = 0; s_vs_cnt = 0; s_fe_cnt = 0; s_fe_last = -1;
    prev_hs = 1'b0;

    // 7601 edges: two full lines plus 300 pixels into line 2, one clk past the enable.
    for (int k = 1; k <= 7601; k++) begin
      @(negedge clk);
      check($sformatf("big_k%0d", k),   32'(got_big()),   32'(exp_big(k)));
      check($sformatf("small_k%0d", k), 32'(got_small()), 32'(exp_small(k)));

      if (k <= 12)   check($sformatf("px_pulse_k%0d", k), 32'(px), 32'((k % 4) == 3));
      if (k == 2559) check("hidx_639", 32'(hidx), 32'd639);
      if (k == 2560) check("hidx_640", 32'({ha, hidx}), 32'({1'b0, 10'd0}));

      if (k <= 3200 && px) begin
        ha_cnt += int'(ha);
        hs_cnt += int'(hs);
      end
      if (hs && !prev_hs) begin
        hs_rises++;
        if (hs_first_k < 0) hs_first_k = k;
        else check("line_len", 32'(k - hs_last_k), 32'd3200);
        hs_last_k = k;
      end
      prev_hs = hs;

      if (k < 240 && s_px) begin
        s_va_cnt += int'(s_va);
        s_vs_cnt += int'(s_vs);
      end
      if (s_fe) begin
        s_fe_cnt++;
        if (s_fe_last < 0) check("small_first_fe_k", 32'(k), 32'd239);
        else check("small_frame_len", 32'(k - s_fe_last), 32'd240);
        s_fe_last = k;
      end
    end

    check("line_haddr_px", 32'(ha_cnt), 32'd640);
    check("line_hsync_px", 32'(hs_cnt), 32'd96);
    check("hsync_start_k", 32'(hs_first_k), 32'd2624);
    check("hsync_rises",   32'(hs_rises), 32'd2);
    check("small_vaddr_px", 32'(s_va_cnt), 32'd60);
    check("small_vsync_px", 32'(s_vs_cnt), 32'd30);
    check("small_fe_count", 32'(s_fe_cnt), 32'd31);
    check("pre_reset_hidx", 32'(hidx), 32'd300);

    // Asynchronous reset between clk edges, mid-line.
    #2 rst = 1'b1;
    #1;
    check("async_reset_big",   32'(got_big()),   32'(exp_big(0)));
    check("async_reset_small", 32'(got_small()), 32'(exp_small(0)));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      check($sformatf("restart_big_k%0d", k),   32'(got_big()),   32'(exp_big(k)));
      check($sformatf("restart_small_k%0d", k), 32'(got_small()), 32'(exp_small(k)));
      if (k == 3) check("restart_first_px", 32'(px), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
